// File: rtl/bcd_timer_ctrl_if.sv
// Host <-> BCD timer controller bus: start/done handshake, run controls and count readback.
// master = host side, slave = controller side.
interface bcd_timer_ctrl_if #(
    parameter int DIGITS = 2
);
    localparam int W = 4 * DIGITS;

    logic         start;
    logic         up_down;
    logic [W-1:0] load_val;
    logic [W-1:0] target;
    logic         pause;
    logic         abort;
    logic [W-1:0] count;
    logic         busy;
    logic         done;

    modport master (
        output start, up_down, load_val, target, pause, abort,
        input  count, busy, done
    );

    modport slave (
        input  start, up_down, load_val, target, pause, abort,
        output count, busy, done
    );
endinterface

// File: rtl/bcd_timer_ctrl.sv
// Sequencing controller for a cascaded BCD counter: load, prescaled up/down count to target, done pulse.
// Optional BCD_TIMER_AUTO_RELOAD_EN: DONE reloads and repeats instead of returning to IDLE.
module bcd_timer_ctrl #(
    parameter int DIGITS   = 2,
    parameter int PRESCALE = 1
) (
    input  logic             clk,
    input  logic             rst,
    bcd_timer_ctrl_if.slave  bus
);
    localparam int W  = 4 * DIGITS;
    localparam int PW = $clog2(PRESCALE + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_HOLD,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [W-1:0]  count_q, count_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          dir_q, dir_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic [W-1:0]  sanitized;
    logic [W-1:0]  stepped;
    logic          step_c;

    // Non-decimal digits in the load value are forced to 0 so count stays BCD.
    for (genvar i = 0; i < DIGITS; i++) begin : g_san
        assign sanitized[4*i +: 4] = (bus.load_val[4*i +: 4] > 4'd9) ? 4'd0 : bus.load_val[4*i +: 4];
    end

    // Ripple carry/borrow across decades; step_c marks that this digit still has to move.
    always_comb begin
        stepped = count_q;
        step_c  = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (step_c) begin
                if (dir_q) begin
                    if (count_q[4*i +: 4] == 4'd9) begin
                        stepped[4*i +: 4] = 4'd0;
                    end else begin
                        stepped[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
                        step_c            = 1'b0;
                    end
                end else begin
                    if (count_q[4*i +: 4] == 4'd0) begin
                        stepped[4*i +: 4] = 4'd9;
                    end else begin
                        stepped[4*i +: 4] = count_q[4*i +: 4] - 4'd1;
                        step_c            = 1'b0;
                    end
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        presc_d = presc_q;
        dir_d   = dir_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    dir_d   = bus.up_down;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (bus.abort) begin
                    state_d = S_IDLE;
                end else begin
                    count_d = sanitized;
                    presc_d = '0;
                    state_d = (sanitized == bus.target) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (bus.abort) begin
                    state_d = S_IDLE;
                end else if (bus.pause) begin
                    state_d = S_HOLD;
                end else if (presc_q == PW'(PRESCALE - 1)) begin
                    presc_d = '0;
                    count_d = stepped;
                    if (stepped == bus.target) state_d = S_DONE;
                end else begin
                    presc_d = presc_q + PW'(1);
                end
            end
            S_HOLD: begin
                if (bus.abort)       state_d = S_IDLE;
                else if (!bus.pause) state_d = S_RUN;
            end
            S_DONE: begin
`ifdef BCD_TIMER_AUTO_RELOAD_EN
                state_d = bus.abort ? S_IDLE : S_LOAD;
`else
                state_d = S_IDLE;
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Status flags are registered from the current state, so they trail state by one cycle.
    always_comb begin
`ifdef BCD_TIMER_AUTO_RELOAD_EN
        busy_d = (state_q != S_IDLE);
`else
        busy_d = (state_q == S_LOAD) || (state_q == S_RUN) || (state_q == S_HOLD);
`endif
        done_d = (state_q == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            count_q <= '0;
            presc_q <= '0;
            dir_q   <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            presc_q <= presc_d;
            dir_q   <= dir_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.count = count_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
endmodule

// File: tb/tb_bcd_timer_ctrl.sv
// Directed self-checking bench for bcd_timer_ctrl: PRESCALE=1 and PRESCALE=4 instances, shared clk/rst.
module tb_bcd_timer_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_bad = 0;
    logic [7:0] ex [8];

    always #5 clk = ~clk;

    bcd_timer_ctrl_if #(.DIGITS(2)) if1 ();
    bcd_timer_ctrl_if #(.DIGITS(2)) if4 ();

    bcd_timer_ctrl #(.DIGITS(2), .PRESCALE(1)) u_dut1 (.clk(clk), .rst(rst), .bus(if1));
    bcd_timer_ctrl #(.DIGITS(2), .PRESCALE(4)) u_dut4 (.clk(clk), .rst(rst), .bus(if4));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        if1.start = 0; if1.up_down = 1; if1.load_val = 0; if1.target = 0; if1.pause = 0; if1.abort = 0;
        if4.start = 0; if4.up_down = 1; if4.load_val = 0; if4.target = 0; if4.pause = 0; if4.abort = 0;
    endtask

    // One full sequence on the PRESCALE=1 instance: expected counts in ex[0..n-1], then the done pulse.
    task automatic run_seq(input string tag, input logic dir, input logic [7:0] ld, input logic [7:0] tg,
                           input int n, input bit hold_start, input int glitch_at);
        if1.start = 1; if1.up_down = dir; if1.load_val = ld; if1.target = tg;
        tick();
        if (!hold_start) if1.start = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            chk($sformatf("%s cnt%0d", tag, i), {24'h0, if1.count}, {24'h0, ex[i]});
            chk($sformatf("%s busy%0d", tag, i), {31'h0, if1.busy}, 32'd1);
            chk($sformatf("%s nodone%0d", tag, i), {31'h0, if1.done}, 32'd0);
            if (i == glitch_at) begin
                rst = 1; #2; rst = 0;
            end
        end
        if1.start = 0;
        tick();
        chk({tag, " done"}, {31'h0, if1.done}, 32'd1);
        chk({tag, " busy_fall"}, {31'h0, if1.busy}, 32'd0);
        chk({tag, " cnt_hold"}, {24'h0, if1.count}, {24'h0, tg});
        tick();
        chk({tag, " done_1cyc"}, {31'h0, if1.done}, 32'd0);
    endtask

    initial begin
        // reset with random inputs
        idle_inputs();
        rst = 1;
        for (int i = 0; i < 2; i++) begin
            if1.start = 1'($urandom); if1.up_down = 1'($urandom);
            if1.load_val = 8'($urandom); if1.target = 8'($urandom);
            if1.pause = 1'($urandom); if1.abort = 1'($urandom);
            tick();
        end
        chk("rst count", {24'h0, if1.count}, 32'h0);
        chk("rst busy", {31'h0, if1.busy}, 32'd0);
        chk("rst done", {31'h0, if1.done}, 32'd0);
        idle_inputs();
        rst = 0;
        tick();

        // up 07 -> 12, with a between-edge rst glitch after 09
        ex = '{8'h07, 8'h08, 8'h09, 8'h10, 8'h11, 8'h12, 8'h00, 8'h00};
        run_seq("up07", 1'b1, 8'h07, 8'h12, 6, 1'b0, 2);

        // down 01 -> 98 across the wrap
        ex = '{8'h01, 8'h00, 8'h99, 8'h98, 8'h00, 8'h00, 8'h00, 8'h00};
        run_seq("dn01", 1'b0, 8'h01, 8'h98, 4, 1'b0, -1);

        // load equals target: no steps
        ex = '{8'h45, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        run_seq("eq45", 1'b0, 8'h45, 8'h45, 1, 1'b0, -1);

        // non-BCD low digit sanitized, start held high while busy
        ex = '{8'h30, 8'h31, 8'h32, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        run_seq("san3C", 1'b1, 8'h3C, 8'h32, 3, 1'b1, -1);

        // PRESCALE=4: phase, pause, abort
        if4.start = 1; if4.up_down = 1; if4.load_val = 8'h00; if4.target = 8'h09;
        tick();
        if4.start = 0;
        tick();
        chk("p4 load", {24'h0, if4.count}, 32'h00);
        for (int i = 0; i < 3; i++) tick();
        chk("p4 pre", {24'h0, if4.count}, 32'h00);
        tick();
        chk("p4 step1", {24'h0, if4.count}, 32'h01);
        for (int i = 0; i < 4; i++) tick();
        chk("p4 step2", {24'h0, if4.count}, 32'h02);
        tick();
        if4.pause = 1;
        for (int i = 0; i < 6; i++) tick();
        chk("p4 paused cnt", {24'h0, if4.count}, 32'h02);
        chk("p4 paused busy", {31'h0, if4.busy}, 32'd1);
        if4.pause = 0;
        for (int i = 0; i < 3; i++) tick();
        chk("p4 phase hold", {24'h0, if4.count}, 32'h02);
        tick();
        chk("p4 phase step", {24'h0, if4.count}, 32'h03);
        if4.abort = 1;
        tick();
        if4.abort = 0;
        tick();
        chk("p4 abort busy", {31'h0, if4.busy}, 32'd0);
        chk("p4 abort cnt", {24'h0, if4.count}, 32'h03);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk($sformatf("p4 abort nodone%0d", i), {31'h0, if4.done}, 32'd0);
        end
        chk("p4 abort cnt2", {24'h0, if4.count}, 32'h03);

        // rst mid-run at count 05
        if1.start = 1; if1.up_down = 1; if1.load_val = 8'h00; if1.target = 8'h20;
        tick();
        if1.start = 0;
        for (int i = 0; i < 6; i++) tick();
        chk("mid cnt05", {24'h0, if1.count}, 32'h05);
        rst = 1;
        tick();
        rst = 0;
        chk("mid rst cnt", {24'h0, if1.count}, 32'h00);
        chk("mid rst busy", {31'h0, if1.busy}, 32'd0);
        for (int i = 0; i < 25; i++) begin
            tick();
            chk($sformatf("mid nodone%0d", i), {31'h0, if1.done}, 32'd0);
        end
        chk("mid idle cnt", {24'h0, if1.count}, 32'h00);

`ifdef BCD_TIMER_AUTO_RELOAD_EN
        // auto reload: period LOAD,RUN,RUN,DONE -> done every 4 cycles
        if1.start = 1; if1.up_down = 1; if1.load_val = 8'h00; if1.target = 8'h02;
        tick();
        if1.start = 0;
        for (int t = 1; t <= 12; t++) begin
            tick();
            chk($sformatf("ar done t%0d", t), {31'h0, if1.done}, {31'h0, (t % 4) == 0});
            chk($sformatf("ar busy t%0d", t), {31'h0, if1.busy}, 32'd1);
        end
        if1.abort = 1;
        tick();
        if1.abort = 0;
        tick();
        chk("ar abort busy", {31'h0, if1.busy}, 32'd0);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk($sformatf("ar nodone%0d", i), {31'h0, if1.done}, 32'd0);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
